// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared tank/bullet constants, encodings and muzzle offsets
package tank_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [2:0] BD_IDLE = 3'b000;
    localparam int         BD_LIVE = 2;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [7:0] PARK_X = 8'd147;
    localparam logic [6:0] PARK_Y = 7'd109;

    localparam logic [8:0] MUZZLE_UP_X    = 9'd4;
    localparam logic [8:0] MUZZLE_UP_Y    = 9'd0;
    localparam logic [8:0] MUZZLE_DOWN_X  = 9'd4;
    localparam logic [8:0] MUZZLE_DOWN_Y  = 9'd8;
    localparam logic [8:0] MUZZLE_LEFT_X  = 9'd0;
    localparam logic [8:0] MUZZLE_LEFT_Y  = 9'd4;
    localparam logic [8:0] MUZZLE_RIGHT_X = 9'd8;
    localparam logic [8:0] MUZZLE_RIGHT_Y = 9'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        COOL = 2'd2
    } state_t;

    function automatic logic [8:0] muzzle_dx(input logic [1:0] dir);
        case (dir)
            DIR_UP:   return MUZZLE_UP_X;
            DIR_DOWN: return MUZZLE_DOWN_X;
            DIR_LEFT: return MUZZLE_LEFT_X;
            default:  return MUZZLE_RIGHT_X;
        endcase
    endfunction

    function automatic logic [8:0] muzzle_dy(input logic [1:0] dir);
        case (dir)
            DIR_UP:   return MUZZLE_UP_Y;
            DIR_DOWN: return MUZZLE_DOWN_Y;
            DIR_LEFT: return MUZZLE_LEFT_Y;
            default:  return MUZZLE_RIGHT_Y;
        endcase
    endfunction

endpackage

// File: rtl/bullet_step.sv
// rtl/bullet_step.sv - next bullet base and out-of-bounds test for one step
module bullet_step
    import tank_pkg::*;
#(
    parameter int STEP  = 2,
    parameter int X_MIN = 1,
    parameter int X_MAX = 158,
    parameter int Y_MIN = 1,
    parameter int Y_MAX = 118
) (
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    input  logic [1:0] dir,
    output logic [7:0] next_x,
    output logic [6:0] next_y,
    output logic       oob
);

    localparam logic [8:0] STEP9  = 9'(STEP);
    localparam logic [7:0] STEP8  = 8'(STEP);
    localparam logic [6:0] STEP7  = 7'(STEP);
    localparam logic [8:0] X_MIN9 = 9'(X_MIN);
    localparam logic [8:0] X_MAX9 = 9'(X_MAX);
    localparam logic [8:0] Y_MIN9 = 9'(Y_MIN);
    localparam logic [8:0] Y_MAX9 = 9'(Y_MAX);

    logic [8:0] real_x, real_y;
    logic [8:0] next_real_x, next_real_y;
    logic       underflow;

    // Bounds apply to the drawn pixel (base + muzzle), not to the base itself.
    always_comb begin
        real_x      = {1'b0, base_x} + muzzle_dx(dir);
        real_y      = {2'b0, base_y} + muzzle_dy(dir);
        next_real_x = real_x;
        next_real_y = real_y;
        next_x      = base_x;
        next_y      = base_y;
        underflow   = 1'b0;
        case (dir)
            DIR_UP: begin
                underflow   = real_y < STEP9;
                next_real_y = real_y - STEP9;
                next_y      = base_y - STEP7;
            end
            DIR_DOWN: begin
                next_real_y = real_y + STEP9;
                next_y      = base_y + STEP7;
            end
            DIR_LEFT: begin
                underflow   = real_x < STEP9;
                next_real_x = real_x - STEP9;
                next_x      = base_x - STEP8;
            end
            default: begin
                next_real_x = real_x + STEP9;
                next_x      = base_x + STEP8;
            end
        endcase
        oob = underflow
            || (next_real_x < X_MIN9) || (next_real_x > X_MAX9)
            || (next_real_y < Y_MIN9) || (next_real_y > Y_MAX9);
    end

endmodule

// File: rtl/bullet_ctrl.sv
// rtl/bullet_ctrl.sv - per-tank bullet launch/flight/retire engine; BULLET_BOUNCE_EN adds one wall reflection
module bullet_ctrl
    import tank_pkg::*;
#(
    parameter int         STEP           = 2,
    parameter int         COOLDOWN_TICKS = 8,
    parameter int         X_MIN          = 1,
    parameter int         X_MAX          = 158,
    parameter int         Y_MIN          = 1,
    parameter int         Y_MAX          = 118,
    parameter logic [7:0] PARK_BX        = PARK_X,
    parameter logic [6:0] PARK_BY        = PARK_Y
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic       fire,
    input  logic       tank_alive,
    input  logic [7:0] tank_x,
    input  logic [6:0] tank_y,
    input  logic [1:0] tank_d,
    input  logic       hit,
    output logic [7:0] bx,
    output logic [6:0] by,
    output logic       be,
    output logic [2:0] bd,
    output logic       fired,
    output logic       retired
);

    localparam int CW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    next_x;
    logic [6:0]    next_y;
    logic          oob;
    logic          can_bounce;
    logic          retire_now;

`ifdef BULLET_BOUNCE_EN
    logic bounced;
`endif

    bullet_step #(
        .STEP  (STEP),
        .X_MIN (X_MIN),
        .X_MAX (X_MAX),
        .Y_MIN (Y_MIN),
        .Y_MAX (Y_MAX)
    ) u_step (
        .base_x (bx),
        .base_y (by),
        .dir    (bd[1:0]),
        .next_x (next_x),
        .next_y (next_y),
        .oob    (oob)
    );

    // hit and tank death outrank the tick, so a same-cycle hit never advances the bullet.
    always_comb begin
        can_bounce = 1'b0;
`ifdef BULLET_BOUNCE_EN
        can_bounce = !bounced;
`endif
        retire_now = !tank_alive || hit || (tick && oob && !can_bounce);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            bx      <= PARK_BX;
            by      <= PARK_BY;
            be      <= 1'b0;
            bd      <= BD_IDLE;
            fired   <= 1'b0;
            retired <= 1'b0;
            cnt     <= '0;
`ifdef BULLET_BOUNCE_EN
            bounced <= 1'b0;
`endif
        end else begin
            fired   <= 1'b0;
            retired <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire && tank_alive) begin
                        bx    <= tank_x;
                        by    <= tank_y;
                        bd    <= {1'b1, tank_d};
                        be    <= 1'b1;
                        fired <= 1'b1;
                        state <= FLY;
`ifdef BULLET_BOUNCE_EN
                        bounced <= 1'b0;
`endif
                    end
                end
                FLY: begin
                    if (retire_now) begin
                        bx      <= PARK_BX;
                        by      <= PARK_BY;
                        be      <= 1'b0;
                        bd      <= BD_IDLE;
                        retired <= 1'b1;
                        if (COOLDOWN_TICKS > 0) begin
                            cnt   <= CW'(COOLDOWN_TICKS);
                            state <= COOL;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (tick) begin
                        if (oob) begin
`ifdef BULLET_BOUNCE_EN
                            // Reflect in place: flipping bit0 swaps up/down and left/right.
                            bd[0]   <= ~bd[0];
                            bounced <= 1'b1;
`endif
                        end else begin
                            bx <= next_x;
                            by <= next_y;
                        end
                    end
                end
                COOL: begin
                    if (tick) begin
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_ctrl.sv
// tb/tb_bullet_ctrl.sv - self-checking bench for bullet_ctrl (vectors, corner sequences, random vs model)
module tb_bullet_ctrl;

    localparam int S    = 2;
    localparam int COOL = 8;
`ifdef BULLET_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0, tick = 1'b0, fire = 1'b0, tank_alive = 1'b0, hit = 1'b0;
    logic [7:0] tank_x = '0;
    logic [6:0] tank_y = '0;
    logic [1:0] tank_d = '0;
    logic [7:0] bx;
    logic [6:0] by;
    logic       be, fired, retired;
    logic [2:0] bd;

    int checks = 0;
    int passes = 0;

    bullet_ctrl dut (
        .clk(clk), .resetn(resetn), .tick(tick), .fire(fire), .tank_alive(tank_alive),
        .tank_x(tank_x), .tank_y(tank_y), .tank_d(tank_d), .hit(hit),
        .bx(bx), .by(by), .be(be), .bd(bd), .fired(fired), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] pack(input int x, input int y, input bit e,
                                         input int d, input bit f, input bit r);
        return {8'(x), 7'(y), e, 3'(d), f, r};
    endfunction

    function automatic logic [20:0] park_out(input bit r);
        return pack(147, 109, 1'b0, 0, 1'b0, r);
    endfunction

    wire [20:0] dut_out = {bx, by, be, bd, fired, retired};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: live/cooling/idle bookkeeping in plain integers.
    int m_st = 0;  // 0 idle, 1 flying, 2 cooling
    int m_x, m_y, m_dir, m_cnt;
    bit m_b, m_f, m_r;
    int MX[4] = '{4, 4, 0, 8};
    int MY[4] = '{0, 8, 4, 4};
    int VX[4] = '{0, 0, -S, S};
    int VY[4] = '{-S, S, 0, 0};

    function automatic logic [20:0] model_out();
        if (m_st == 1) return pack(m_x, m_y, 1'b1, 4 + m_dir, m_f, m_r);
        return park_out(m_r);
    endfunction

    task automatic model_retire();
        m_r   = 1'b1;
        m_cnt = COOL;
        m_st  = (COOL > 0) ? 2 : 0;
    endtask

    task automatic model_step();
        int rx, ry;
        m_f = 1'b0;
        m_r = 1'b0;
        if (!resetn) begin
            m_st = 0; m_cnt = 0; m_b = 1'b0;
        end else if (m_st == 0) begin
            if (fire && tank_alive) begin
                m_st = 1; m_x = tank_x; m_y = tank_y; m_dir = tank_d; m_f = 1'b1; m_b = 1'b0;
            end
        end else if (m_st == 1) begin
            if (!tank_alive || hit) model_retire();
            else if (tick) begin
                rx = m_x + MX[m_dir] + VX[m_dir];
                ry = m_y + MY[m_dir] + VY[m_dir];
                if (rx < 1 || rx > 158 || ry < 1 || ry > 118) begin
                    if (BOUNCE && !m_b) begin
                        m_dir = m_dir ^ 1; m_b = 1'b1;
                    end else model_retire();
                end else begin
                    m_x = m_x + VX[m_dir];
                    m_y = m_y + VY[m_dir];
                end
            end
        end else if (tick) begin
            m_cnt--;
            if (m_cnt == 0) m_st = 0;
        end
    endtask

    task automatic drive(input bit rn, input bit tk, input bit fr, input bit al, input bit ht,
                         input int tx, input int ty, input int td);
        resetn = rn; tick = tk; fire = fr; tank_alive = al; hit = ht;
        tank_x = 8'(tx); tank_y = 7'(ty); tank_d = 2'(td);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          rn, tk, fr, al, ht;
        int          tx, ty, td;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit rn, input bit tk, input bit fr, input bit al, input bit ht,
                                input int tx, input int ty, input int td, input logic [20:0] e);
        vec_t v;
        v.rn = rn; v.tk = tk; v.fr = fr; v.al = al; v.ht = ht;
        v.tx = tx; v.ty = ty; v.td = td; v.exp = e;
        return v;
    endfunction

    initial begin
        int n;
        bit done;

        vecs.push_back(mk(0, 0, 0, 1, 0,  20, 50, 0, park_out(0)));
        vecs.push_back(mk(1, 0, 1, 1, 0,  20, 50, 0, pack(20, 50, 1, 4, 1, 0)));
        vecs.push_back(mk(1, 1, 0, 1, 0,  20, 50, 0, pack(20, 48, 1, 4, 0, 0)));
        vecs.push_back(mk(1, 1, 1, 1, 0,  20, 50, 0, pack(20, 46, 1, 4, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 1, 0,  20, 50, 0, pack(20, 46, 1, 4, 0, 0)));
        vecs.push_back(mk(1, 1, 0, 1, 0,  20, 50, 0, pack(20, 44, 1, 4, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 0, 0,  20, 50, 0, park_out(1)));
        vecs.push_back(mk(0, 0, 0, 1, 0,  20, 50, 0, park_out(0)));
        vecs.push_back(mk(1, 0, 1, 1, 0, 148, 10, 3, pack(148, 10, 1, 7, 1, 0)));
        vecs.push_back(mk(1, 1, 0, 1, 0, 148, 10, 3, pack(150, 10, 1, 7, 0, 0)));
        vecs.push_back(mk(1, 1, 0, 1, 0, 148, 10, 3, park_out(1)));
        vecs.push_back(mk(0, 0, 0, 1, 0, 148, 10, 3, park_out(0)));
        vecs.push_back(mk(1, 0, 1, 0, 0,  30, 40, 1, park_out(0)));
        vecs.push_back(mk(1, 0, 1, 1, 0,  30, 40, 1, pack(30, 40, 1, 5, 1, 0)));
        vecs.push_back(mk(0, 1, 1, 1, 0,  30, 40, 1, park_out(0)));

        foreach (vecs[i]) begin
            drive(vecs[i].rn, vecs[i].tk, vecs[i].fr, vecs[i].al, vecs[i].ht,
                  vecs[i].tx, vecs[i].ty, vecs[i].td);
            cycle();
            check($sformatf("vec%0d", i), 32'(dut_out), 32'(vecs[i].exp));
        end

        // hit with tick retires without advancing, then cooldown blocks a held fire
        drive(0, 0, 0, 1, 0, 60, 42, 0); cycle();
        drive(1, 0, 1, 1, 0, 60, 42, 0); cycle();
        check("cd_launch", 32'(dut_out), 32'(pack(60, 42, 1, 4, 1, 0)));
        drive(1, 1, 1, 1, 0, 60, 42, 0); cycle();
        check("cd_tick", 32'(dut_out), 32'(pack(60, 40, 1, 4, 0, 0)));
        drive(1, 1, 1, 1, 1, 60, 42, 0); cycle();
        check("cd_hit_tick", 32'(dut_out), 32'(park_out(1)));
        hit = 1'b0;
        for (int i = 1; i <= COOL; i++) begin
            tick = 1'b1; cycle();
            check($sformatf("cd_tick%0d", i), 32'(be), 32'(0));
            tick = 1'b0; cycle();
            if (i < COOL) check($sformatf("cd_gap%0d", i), 32'(be), 32'(0));
            else check("cd_relaunch", 32'(dut_out), 32'(pack(60, 42, 1, 4, 1, 0)));
        end

        // fire down from y=100: bottom wall reached on the sixth tick
        drive(0, 0, 0, 1, 0, 30, 100, 1); cycle();
        drive(1, 0, 1, 1, 0, 30, 100, 1); cycle();
        check("bn_launch", 32'(dut_out), 32'(pack(30, 100, 1, 5, 1, 0)));
        fire = 1'b0; tick = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        check("bn_bottom", 32'(dut_out), 32'(pack(30, 110, 1, 5, 0, 0)));
        cycle();
`ifdef BULLET_BOUNCE_EN
        check("bn_reflect", 32'(dut_out), 32'(pack(30, 110, 1, 4, 0, 0)));
        n = 0; done = 1'b0;
        while (!done && n < 200) begin
            cycle(); n++;
            if (retired) done = 1'b1;
        end
        check("bn_ticks_to_top", 32'(n), 32'(55));
        check("bn_retired_out", 32'(dut_out), 32'(park_out(1)));
`else
        check("bn_retire", 32'(dut_out), 32'(park_out(1)));
`endif

        // random traffic against the model
        drive(0, 0, 0, 1, 0, 0, 0, 0); cycle();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99) != 0, $urandom_range(1), $urandom_range(9) < 3,
                  $urandom_range(19) != 0, $urandom_range(19) == 0,
                  (i % 7 == 0) ? $urandom_range(255) : $urandom_range(20, 140),
                  (i % 7 == 0) ? $urandom_range(127) : $urandom_range(10, 100),
                  $urandom_range(3));
            cycle();
            check($sformatf("rand%0d", i), 32'(dut_out), 32'(model_out()));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
